// File: rtl/sync_down_counter_jk.sv
// Synchronous down counter built from one JK flip-flop per bit.
// The count runs down to zero and then wraps to RELOAD. A one-cycle wrap pulse
// is registered after each wrap. A parallel load overrides counting.

// Single JK flip-flop with an asynchronous active-low reset.
module jk_ff (
    input  logic clk,
    input  logic rst_n,
    input  logic j,
    input  logic k,
    output logic q
);

    // JK behaviour: 00 hold, 01 clear, 10 set, 11 toggle
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            q <= 1'b0;
        end else begin
            case ({j, k})
                2'b01:   q <= 1'b0;
                2'b10:   q <= 1'b1;
                2'b11:   q <= ~q;
                default: q <= q;
            endcase
        end
    end

endmodule

module sync_down_counter_jk #(
    parameter int              WIDTH  = 4,
    parameter logic [WIDTH-1:0] RELOAD = '1
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             en,
    input  logic             load,
    input  logic [WIDTH-1:0] d,
    output logic [WIDTH-1:0] q,
    output logic             tc,
    output logic             wrap
);

    logic             zero;
    logic [WIDTH-1:0] j;
    logic [WIDTH-1:0] k;

    assign zero = (q == '0);
    assign tc   = en & ~load & zero;

    // Per-stage J/K steering: load forces d, wrap forces RELOAD,
    // count toggles a stage once all lower bits are zero, otherwise hold.
    always_comb begin
        j = '0;
        k = '0;
        for (int unsigned i = 0; i < WIDTH; i++) begin
            logic lower_zero;
            lower_zero = 1'b1;
            for (int unsigned m = 0; m < i; m++) begin
                lower_zero = lower_zero & ~q[m];
            end
            if (load) begin
                j[i] = d[i];
                k[i] = ~d[i];
            end else if (en) begin
                if (zero) begin
                    j[i] = RELOAD[i];
                    k[i] = ~RELOAD[i];
                end else begin
                    j[i] = lower_zero;
                    k[i] = lower_zero;
                end
            end
        end
    end

    genvar g;
    generate
        for (g = 0; g < WIDTH; g++) begin : g_stage
            jk_ff u_ff (
                .clk   (clk),
                .rst_n (reset),
                .j     (j[g]),
                .k     (k[g]),
                .q     (q[g])
            );
        end
    endgenerate

    // Wrap pulse: high for the cycle after a 0 -> RELOAD transition
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            wrap <= 1'b0;
        end else begin
            wrap <= tc;
        end
    end

endmodule

// File: tb/tb_sync_down_counter_jk.sv
// Directed bench for sync_down_counter_jk. It uses two instances:
// RELOAD=15 (default) and RELOAD=9. Both share the same stimulus.
module tb_sync_down_counter_jk;

    logic       clk;
    logic       reset;
    logic       en;
    logic       load;
    logic [3:0] d;
    logic [3:0] q15, q9;
    logic       tc15, tc9, wrap15, wrap9;

    int n_vec;
    int n_bad;

    sync_down_counter_jk #(.WIDTH(4)) dut15 (
        .clk(clk), .reset(reset), .en(en), .load(load), .d(d),
        .q(q15), .tc(tc15), .wrap(wrap15)
    );

    sync_down_counter_jk #(.WIDTH(4), .RELOAD(4'd9)) dut9 (
        .clk(clk), .reset(reset), .en(en), .load(load), .d(d),
        .q(q9), .tc(tc9), .wrap(wrap9)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic       en;
        logic       load;
        logic [3:0] d;
        logic       exp_tc;   // before the edge
        logic [3:0] exp_q;    // after the edge
        logic       exp_wrap; // after the edge
    } vec_t;

    vec_t vecs[$];

    task automatic check(input string name, input int act, input int exp);
        n_vec++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0d, expected %0d at %0t", name, act, exp, $time);
        end
    endtask

    function automatic void add(input logic e, input logic l, input logic [3:0] dv,
                                input logic t, input logic [3:0] eq, input logic w);
        vec_t v;
        v.en = e; v.load = l; v.d = dv; v.exp_tc = t; v.exp_q = eq; v.exp_wrap = w;
        vecs.push_back(v);
    endfunction

    initial begin
        int exp15, exp9, wraps9;
        n_vec = 0;
        n_bad = 0;

        // Table for the RELOAD=9 instance. It starts from q=0 after reset.
        add(1, 0, 4'd0, 1, 4'd9, 1);            // wrap from 0
        add(1, 0, 4'd0, 0, 4'd8, 0);
        add(1, 0, 4'd0, 0, 4'd7, 0);
        for (int i = 0; i < 5; i++) add(0, 0, 4'd0, 0, 4'd7, 0); // hold at 7
        add(1, 0, 4'd0, 0, 4'd6, 0);
        add(1, 1, 4'hC, 0, 4'd12, 0);           // load wins over en, d > RELOAD
        for (int v = 11; v >= 0; v--) add(1, 0, 4'd0, 0, 4'(v), 0);
        add(1, 0, 4'd0, 1, 4'd9, 1);
        add(1, 0, 4'd0, 0, 4'd8, 0);
        add(0, 1, 4'd0, 0, 4'd0, 0);            // load 0
        add(0, 0, 4'd0, 0, 4'd0, 0);            // hold at 0: tc low with en=0
        add(1, 0, 4'd0, 1, 4'd9, 1);            // tc then wrap
        add(0, 1, 4'd13, 0, 4'd13, 0);          // load 13
        for (int v = 12; v >= 0; v--) add(1, 0, 4'd0, 0, 4'(v), 0);
        add(1, 0, 4'd0, 1, 4'd9, 1);
        add(1, 1, 4'd0, 0, 4'd0, 0);            // load at q=9 with en
        add(1, 1, 4'd0, 0, 4'd0, 0);            // load 0 again: tc suppressed

        // Reset for 12 ns with en=1 held.
        reset = 1'b0; en = 1'b1; load = 1'b0; d = 4'd0;
        #2;
        check("rst_q15", q15, 0);
        check("rst_q9", q9, 0);
        check("rst_wrap15", wrap15, 0);
        check("rst_tc15", tc15, 1);
        #10 reset = 1'b1;

        // Free run on both instances.
        wraps9 = 0;
        for (int k = 1; k <= 25; k++) begin
            @(posedge clk); #1;
            exp15 = (16 - (k % 16)) % 16;
            exp9  = (10 - (k % 10)) % 10;
            check("run_q15", q15, exp15);
            check("run_wrap15", wrap15, (exp15 == 15) ? 1 : 0);
            check("run_tc15", tc15, (exp15 == 0) ? 1 : 0);
            check("run_q9", q9, exp9);
            check("run_wrap9", wrap9, (exp9 == 9) ? 1 : 0);
            if (q9 > 4'd9) check("run_q9_range", q9, 9);
            if (wrap9) wraps9++;
        end
        check("wrap9_count", wraps9, 3);

        // Load 5, then apply an asynchronous reset between clock edges.
        load = 1'b1; d = 4'd5; en = 1'b0;
        @(posedge clk); #1;
        load = 1'b0;
        check("ld5_q9", q9, 5);
        #2 reset = 1'b0;
        #1;
        check("async_q9", q9, 0);
        check("async_q15", q15, 0);
        en = 1'b1;
        #1 reset = 1'b1;
        @(posedge clk); #1;
        check("rel_q9", q9, 9);
        check("rel_wrap9", wrap9, 1);
        check("rel_q15", q15, 15);
        check("rel_wrap15", wrap15, 1);

        // Return to q=0 with en low, then run the table.
        en = 1'b0;
        #1 reset = 1'b0;
        #2 reset = 1'b1;
        check("pre_tbl_q9", q9, 0);
        foreach (vecs[i]) begin
            en = vecs[i].en; load = vecs[i].load; d = vecs[i].d;
            #1;
            check($sformatf("tbl%0d_tc", i), tc9, vecs[i].exp_tc);
            @(posedge clk); #1;
            check($sformatf("tbl%0d_q", i), q9, vecs[i].exp_q);
            check($sformatf("tbl%0d_wrap", i), wrap9, vecs[i].exp_wrap);
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end

endmodule

// File: doc/sync_down_counter_jk.md
SYNC_DOWN_COUNTER_JK -- requirements
Module: sync_down_counter_jk

Interface
REQ-001 The block SHALL provide parameter WIDTH, default 4, which sets the counter width in bits (legal range 2..16).
REQ-002 The block SHALL provide parameter RELOAD, default {WIDTH{1'b1}}, which is the wrap value loaded after 0 (legal range 1..2^WIDTH-1).
REQ-003 Port clk, input, 1 bit: the single clock; all state SHALL update on its rising edge.
REQ-004 Port reset, input, 1 bit: asynchronous, active-low reset (0 = reset).
REQ-005 Port en, input, 1 bit: count enable, active-high.
REQ-006 Port load, input, 1 bit: synchronous parallel load, active-high.
REQ-007 Port d, input, WIDTH bits: parallel load value.
REQ-008 Port q, output, WIDTH bits: current count, registered.
REQ-009 Port tc, output, 1 bit: terminal count, combinational; tc = en & ~load & (q == 0).
REQ-010 Port wrap, output, 1 bit: registered one-cycle pulse; it is high for exactly the cycle after q wrapped from 0 to RELOAD.

Function
REQ-011 The counter state SHALL be WIDTH JK flip-flops, one per bit, instantiated from a jk_ff submodule; each jk_ff SHALL have clk, active-low async reset, j, k and q ports.
REQ-012 In count mode (en=1, load=0, q!=0), stage i SHALL be driven with J=K=1 when bits 0..i-1 of q are all 0; stage 0 SHALL be driven with J=K=1 unconditionally. Result: q decrements by 1 per cycle.
REQ-013 When en=1, load=0 and q==0, the next q SHALL be RELOAD (not 2^WIDTH-1 unless RELOAD equals it). The J/K inputs SHALL set or clear each stage to match RELOAD, and wrap SHALL be 1 in the following cycle.
REQ-014 When load=1, the next q SHALL be d, regardless of en. Each stage SHALL be driven with J=d[i], K=~d[i], and wrap SHALL be 0 in the following cycle.
REQ-015 Priority SHALL be reset > load > en.
REQ-016 When en=0 and load=0, q SHALL hold, each stage SHALL be driven with J=K=0, and wrap SHALL be 0 in the following cycle.
REQ-017 A loaded value d > RELOAD SHALL be accepted; the counter SHALL count down from d to 0 and then wrap to RELOAD.
REQ-018 A load of d=0 with en=1 on the next cycle SHALL produce tc=1 in that cycle and a wrap on the following edge.
REQ-019 All count arithmetic SHALL be modulo-free: q never leaves the range 0..max(RELOAD, last loaded d), and there is no X propagation from d when load=0.
REQ-020 With en held high and no loads, the sequence SHALL repeat with period RELOAD+1 cycles, and wrap SHALL pulse once per period.

Reset
REQ-021 When reset=0, q SHALL be 0 and wrap SHALL be 0, immediately and independent of clk.
REQ-022 tc SHALL follow REQ-009 during reset; it is 1 if en=1 and load=0.
REQ-023 When reset is asserted mid-count, the block SHALL abort the count; the first active edge after reset deasserts SHALL act on the current en/load from q=0. With en=1, that means wrap to RELOAD.
REQ-024 Reset deassertion is asynchronous to clk and needs no synchronizer inside the block; the system SHALL provide it glitch-free.

Verification
REQ-025 With WIDTH=4, RELOAD=15: reset low 12 ns, then en=1 for 20 cycles -> q = 0,15,14,...,1,0,15,...; wrap is high in the cycle q=15; tc is high whenever q=0.
REQ-026 With RELOAD=9: free run with en=1 -> q cycles 9..0, period 10; q never exceeds 9; there is one wrap pulse per 10 cycles.
REQ-027 load=1, d=4'hC, with en=1 simultaneously -> next q=12 (load wins), then 11,10,...; wrap stays 0 on the load edge.
REQ-028 en=0 for 5 cycles at q=7 -> q holds 7, tc=0, wrap=0; with en=1 again -> 6 on the next edge.
REQ-029 Assert reset asynchronously (between edges) at q=5 -> q=0 within one time step, without waiting for clk; release with en=1 -> q=RELOAD on the next edge and wrap=1.
REQ-030 At RELOAD=9: load d=13, then count -> 12..0, then 9, with wrap asserted exactly once.
